// File: rtl/prog_rom_loader_pkg.sv
// Shared definitions for the program-memory loader: bus widths, the frame
// sync byte, the loader FSM state encoding and the power-on program image.
package prog_rom_loader_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   localparam logic [DATA_W-1:0] LOAD_SYNC = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LEN  = 2'd1,
      ST_DATA = 2'd2,
      ST_SUM  = 2'd3
   } loader_state_t;

   // Program the CPU runs out of reset; element 0 is address 0.
   localparam logic [DATA_W-1:0] DEFAULT_PROGRAM [DEPTH] = '{
      8'h1F, 8'h2E, 8'h3D, 8'h4C, 8'h5B, 8'h6A, 8'h79, 8'h88,
      8'h97, 8'hA6, 8'hB5, 8'hC4, 8'hD3, 8'hE2, 8'hF1, 8'h00
   };

endpackage

// File: rtl/prog_rom_loader_if.sv
// Instruction-fetch bus between the CPU (master) and program memory (slave).
//   addr : fetch address, driven by the CPU
//   data : instruction byte, driven by the memory
interface mem_bus_if
   import prog_rom_loader_pkg::*;
   ;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;

   modport master (output addr, input data);
   modport slave  (input addr, output data);
endinterface

// File: rtl/prog_rom_loader_fsm.sv
// Framed serial-load sequencer. Parses SYNC, LEN, data bytes and SUM from a
// byte stream, produces memory write strobes, and reports completion/errors.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for SYNC byte; cpu_hold low
// LEN   | SYNC seen, waiting for length byte (1..MAX_LEN)
// DATA  | writing payload bytes to mem[ptr], accumulating sum
// SUM   | waiting for checksum byte
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rx_data, rx_valid     incoming byte and its one-cycle strobe
//   wr_en/wr_addr/wr_data memory write, same-cycle as the accepted byte
//   cpu_hold              registered, high whenever state != IDLE
//   load_done             one-cycle pulse after a good checksum
//   load_err              sticky error, cleared by next SYNC
module loader_fsm
   import prog_rom_loader_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int MAX_LEN        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam int LEN_W = ADDR_W + 1;
   localparam int TMO_W = 20;
   // Abort on the edge where the counter would reach TIMEOUT_CYCLES.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   loader_state_t      state;
   logic [ADDR_W-1:0]  ptr;
   logic [LEN_W-1:0]   len;
   logic [DATA_W-1:0]  sum;
   logic [TMO_W-1:0]   tmo_cnt;
   logic               last_byte;

   assign wr_en     = rx_valid && (state == ST_DATA);
   assign wr_addr   = ptr;
   assign wr_data   = rx_data;
   assign last_byte = ({1'b0, ptr} == (len - LEN_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         len       <= '0;
         sum       <= '0;
         tmo_cnt   <= '0;
         cpu_hold  <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         load_done <= 1'b0;
         if (state == ST_IDLE) begin
            if (rx_valid && (rx_data == LOAD_SYNC)) begin
               load_err <= 1'b0;
               sum      <= '0;
               ptr      <= '0;
               tmo_cnt  <= '0;
               state    <= ST_LEN;
               cpu_hold <= 1'b1;
            end
         end else if (rx_valid) begin
            // A byte always beats a coincident timeout.
            tmo_cnt <= '0;
            case (state)
               ST_LEN: begin
                  if ((rx_data == '0) || (rx_data > DATA_W'(MAX_LEN))) begin
                     load_err <= 1'b1;
                     state    <= ST_IDLE;
                     cpu_hold <= 1'b0;
                  end else begin
                     len   <= rx_data[LEN_W-1:0];
                     state <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  sum <= sum + rx_data;
                  ptr <= ptr + ADDR_W'(1);
                  if (last_byte) begin
                     state <= ST_SUM;
                  end
               end
               ST_SUM: begin
                  if (rx_data == sum) begin
                     load_done <= 1'b1;
                  end else begin
                     load_err <= 1'b1;
                  end
                  state    <= ST_IDLE;
                  cpu_hold <= 1'b0;
               end
               default: begin
                  state    <= ST_IDLE;
                  cpu_hold <= 1'b0;
               end
            endcase
         end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt  <= '0;
            load_err <= 1'b1;
            state    <= ST_IDLE;
            cpu_hold <= 1'b0;
         end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end
      end
   end

endmodule

// File: rtl/prog_rom_loader.sv
// Program memory for the 4-bit CPU. 16x8 register file preset to
// DEFAULT_PROGRAM at reset, read combinationally over mem_bus, and
// rewritable at run time from a framed serial byte stream.
//
// Ports:
//   clk, rst_n   clock, async active-low reset (also restores the program)
//   mem_bus      slave side of the fetch bus; data = mem[addr]
//   rx_data      received byte
//   rx_valid     one-cycle strobe qualifying rx_data
//   cpu_hold     high while a load frame is in progress
//   load_done    one-cycle pulse on a good checksum
//   load_err     sticky error, cleared by next SYNC or reset
module prog_rom_loader
   import prog_rom_loader_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int MAX_LEN        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_bus_if.slave          mem_bus,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] mem [DEPTH];

   loader_fsm #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .MAX_LEN        (MAX_LEN)
   ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_err  (load_err)
   );

   // Partial frames are not rolled back; only reset restores the image.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= DEFAULT_PROGRAM[i];
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign mem_bus.data = mem[mem_bus.addr];

endmodule

// File: tb/tb_prog_rom_loader.sv
module tb_prog_rom_loader;

   logic       clk;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       cpu_hold;
   logic       load_done;
   logic       load_err;

   int n_assert;
   int n_fail;

   logic [7:0] def_prog [16];
   logic [7:0] exp_mem  [16];
   logic [7:0] burst_q  [$];

   mem_bus_if bus ();

   prog_rom_loader #(
      .TIMEOUT_CYCLES (50),
      .MAX_LEN        (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_bus   (bus),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_err  (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_status(input string tag, input logic h, input logic d, input logic e);
      chk({tag, ".cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
      chk({tag, ".load_done"}, {31'd0, load_done}, {31'd0, d});
      chk({tag, ".load_err"}, {31'd0, load_err}, {31'd0, e});
   endtask

   task automatic chk_mem(input string tag);
      for (int i = 0; i < 16; i++) begin
         bus.addr = 4'(i);
         #1;
         chk($sformatf("%s.mem[%0d]", tag, i), {24'd0, bus.data}, {24'd0, exp_mem[i]});
      end
   endtask

   // One byte with a gap cycle after it; returns at the negedge after sampling.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // Bytes of burst_q on consecutive cycles.
   task automatic send_burst();
      @(negedge clk);
      foreach (burst_q[i]) begin
         rx_data  = burst_q[i];
         rx_valid = 1'b1;
         @(negedge clk);
      end
      rx_valid = 1'b0;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      def_prog = '{8'h1F, 8'h2E, 8'h3D, 8'h4C, 8'h5B, 8'h6A, 8'h79, 8'h88,
                   8'h97, 8'hA6, 8'hB5, 8'hC4, 8'hD3, 8'hE2, 8'hF1, 8'h00};
      exp_mem  = def_prog;
      rst_n    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      bus.addr = 4'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset then fetch
      chk_status("reset", 1'b0, 1'b0, 1'b0);
      chk_mem("reset");

      // Good frame A5 03 11 22 33 66
      send_byte(8'hA5);
      chk_status("good.sync", 1'b1, 1'b0, 1'b0);
      send_byte(8'h03);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      chk_status("good.presum", 1'b1, 1'b0, 1'b0);
      send_byte(8'h66);
      chk_status("good.sum", 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk_status("good.after", 1'b0, 1'b0, 1'b0);
      exp_mem[0] = 8'h11; exp_mem[1] = 8'h22; exp_mem[2] = 8'h33;
      chk_mem("good");

      // Bad checksum A5 02 80 90 00 (true sum 0x10)
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h80);
      send_byte(8'h90);
      send_byte(8'h00);
      chk_status("badsum", 1'b0, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      chk_status("badsum.sticky", 1'b0, 1'b0, 1'b1);
      exp_mem[0] = 8'h80; exp_mem[1] = 8'h90;
      chk_mem("badsum");
      send_byte(8'hA5);
      chk_status("resync.clears", 1'b1, 1'b0, 1'b0);

      // Bad length 00 (continues the frame opened above), then A5 11
      send_byte(8'h00);
      chk_status("badlen0", 1'b0, 1'b0, 1'b1);
      send_byte(8'hA5);
      send_byte(8'h11);
      chk_status("badlen17", 1'b0, 1'b0, 1'b1);
      chk_mem("badlen");

      // Timeout: A5 04 AA then idle; abort on the 50th idle cycle
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'hAA);
      repeat (49) @(negedge clk);
      chk_status("tmo.before", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk_status("tmo.expired", 1'b0, 1'b0, 1'b1);
      exp_mem[0] = 8'hAA;
      chk_mem("tmo");

      // Good frame after timeout: A5 04 01 02 03 04 0A
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      send_byte(8'h0A);
      chk_status("reload", 1'b0, 1'b1, 1'b0);
      exp_mem[0] = 8'h01; exp_mem[1] = 8'h02; exp_mem[2] = 8'h03; exp_mem[3] = 8'h04;
      chk_mem("reload");

      // Back-to-back, max length 16: C0..CF, sum = 0xC78 -> 0x78
      burst_q = {8'hA5, 8'h10};
      for (int i = 0; i < 16; i++) begin
         burst_q.push_back(8'hC0 + 8'(i));
         exp_mem[i] = 8'hC0 + 8'(i);
      end
      burst_q.push_back(8'h78);
      send_burst();
      chk_status("len16", 1'b0, 1'b1, 1'b0);
      chk_mem("len16");

      // Back-to-back with A5 as payload: A5 02 5A A5 FF
      burst_q = {8'hA5, 8'h02, 8'h5A, 8'hA5, 8'hFF};
      send_burst();
      chk_status("a5payload", 1'b0, 1'b1, 1'b0);
      exp_mem[0] = 8'h5A; exp_mem[1] = 8'hA5;
      chk_mem("a5payload");

      // Reset during DATA restores the default program
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h77);
      exp_mem[0] = 8'h77;
      chk_status("mid.data", 1'b1, 1'b0, 1'b0);
      chk_mem("mid.data");
      rst_n = 1'b0;
      #1;
      chk_status("mid.reset", 1'b0, 1'b0, 1'b0);
      exp_mem = def_prog;
      chk_mem("mid.reset");
      @(negedge clk);
      rst_n = 1'b1;
      // Remaining bytes of the aborted frame must not be taken as a new frame
      send_byte(8'h55);
      chk_status("post.reset", 1'b0, 1'b0, 1'b0);
      chk_mem("post.reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
